// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Main control unit of a multicycle MIPS-subset datapath. Moore FSM whose
// outputs depend on the current state, with a few opcode/funct/zero/mem_ready
// qualifiers. Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
//
// Parameters
//   ILLEGAL_TRAP : 1 = pulse illegal_op on an unsupported opcode or funct,
//                  0 = illegal_op held 0.
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset (also forces all outputs to 0)
//   opcode     : instruction bits [31:26] from the instruction register
//   funct      : instruction bits [5:0]
//   zero       : ALU zero flag (beq decision)
//   mem_ready  : memory access completes this cycle
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, pc_en, illegal_op : 1-bit datapath controls
//   alu_src_b  : ALU B operand select (00 reg, 01 +4, 10 imm, 11 imm<<2)
//   pc_src     : PC source select (00 ALU, 01 ALU out reg, 10 jump target)
//   alu_ctrl   : ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   state      : debug view of the current state
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_ALUWB;
          default:                               state_d = S_FETCH;
        endcase
      end
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;  // unused encodings 12-15 recover
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Everything defaults to 0; reset masks all outputs so no
  // write strobe can fire while the machine is being forced back to FETCH.
  // ---------------------------------------------------------------------------
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_en      = 1'b0;
    illegal_op = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = 3'b000;
    state      = 4'd0;

    if (!rst) begin
      state = state_q;
      unique case (state_q)
        S_FETCH: begin
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
            default: illegal_op = ILLEGAL_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: begin
              alu_ctrl   = ALU_ADD;
              illegal_op = ILLEGAL_TRAP;
            end
          endcase
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_src    = 2'b01;
          pc_en     = zero;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;  // unused encodings drive nothing
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Scoreboard bench for mc_ctrl_fsm. A stimulus process walks whole
// instructions (with random memory stalls, random don't-care inputs and
// occasional resets) through the instruction-level path each one must take,
// pushing the expected per-cycle control word. A monitor pops and compares
// on every falling edge.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_en;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  // Instruction steps, numbered with the state codes a reader expects to see
  typedef enum int {
    PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3, PH_MEMWB = 4,
    PH_MEMWR = 5, PH_EXECUTE = 6, PH_ALUWB = 7, PH_BEQ = 8, PH_ADDIEX = 9,
    PH_ADDIWB = 10, PH_JUMP = 11
  } ph_t;

  typedef enum int {K_LW, K_SW, K_R, K_RBAD, K_BEQ, K_ADDI, K_J, K_BADOP} kind_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .pc_en(pc_en),
    .illegal_op(illegal_op), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctrl(alu_ctrl), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_t exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // ---------------------------------------------------------------------------
  // Reference rules
  // ---------------------------------------------------------------------------
  function automatic bit op_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b000010};
  endfunction

  function automatic bit fn_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ctrl_t exp_out(input ph_t ph, input logic [5:0] op,
                                    input logic [5:0] fn, input logic z,
                                    input logic mr);
    ctrl_t e;
    e = '0;
    e.state = 4'(int'(ph));
    case (ph)
      PH_FETCH:   begin e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
                        e.ir_write = mr; e.pc_en = mr; end
      PH_DECODE:  begin e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010;
                        e.illegal_op = !op_legal(op); end
      PH_MEMADR:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                        e.alu_ctrl = 3'b010; end
      PH_MEMRD:   e.iord = 1'b1;
      PH_MEMWB:   begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      PH_MEMWR:   begin e.iord = 1'b1; e.mem_write = 1'b1; end
      PH_EXECUTE: begin e.alu_src_a = 1'b1; e.alu_ctrl = fn_alu(fn);
                        e.illegal_op = !fn_legal(fn); end
      PH_ALUWB:   begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      PH_BEQ:     begin e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110;
                        e.pc_src = 2'b01; e.pc_en = z; end
      PH_ADDIEX:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                        e.alu_ctrl = 3'b010; end
      PH_ADDIWB:  e.reg_write = 1'b1;
      PH_JUMP:    begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default:    ;
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // One clock cycle: drive inputs just after the rising edge, record what the
  // DUT must show during this cycle.
  task automatic step(input ph_t ph, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic r, input int zf);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    zero      = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    if (r) exp_q.push_back('0);
    else   exp_q.push_back(exp_out(ph, op, fn, zero, mr));
    tag_q.push_back(r ? "reset" : ph.name());
  endtask

  // Walk one instruction through its path. stalls<0 means random stalls per
  // memory step; zf<0 random zero; fn_force<0 random funct; rst_at>=0 asserts
  // reset (two cycles) when that step of the path is reached, abandoning it.
  task automatic run_instr(input kind_t k, input int stalls, input int zf,
                           input int fn_force, input int rst_at);
    ph_t        path[$];
    logic [5:0] op;
    logic [5:0] fn;
    int         ns;
    op = 6'($urandom);
    fn = 6'($urandom);
    case (k)
      K_LW:   begin op = 6'b100011; path = '{PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB}; end
      K_SW:   begin op = 6'b101011; path = '{PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMWR}; end
      K_R: begin
        op = 6'b000000;
        case ($urandom_range(0, 4))
          0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
          3: fn = 6'b100101; default: fn = 6'b101010;
        endcase
        path = '{PH_FETCH, PH_DECODE, PH_EXECUTE, PH_ALUWB};
      end
      K_RBAD: begin
        op = 6'b000000;
        while (fn_legal(fn)) fn = 6'($urandom);
        path = '{PH_FETCH, PH_DECODE, PH_EXECUTE};
      end
      K_BEQ:  begin op = 6'b000100; path = '{PH_FETCH, PH_DECODE, PH_BEQ}; end
      K_ADDI: begin op = 6'b001000; path = '{PH_FETCH, PH_DECODE, PH_ADDIEX, PH_ADDIWB}; end
      K_J:    begin op = 6'b000010; path = '{PH_FETCH, PH_DECODE, PH_JUMP}; end
      default: begin
        while (op_legal(op)) op = 6'($urandom);
        path = '{PH_FETCH, PH_DECODE};
      end
    endcase
    if (fn_force >= 0) fn = 6'(fn_force);
    for (int i = 0; i < path.size(); i++) begin
      if (i == rst_at) begin
        step(path[i], op, fn, 1'b0, 1'b1, zf);
        step(PH_FETCH, op, fn, 1'b0, 1'b1, zf);
        return;
      end
      if (path[i] inside {PH_FETCH, PH_MEMRD, PH_MEMWR}) begin
        ns = (stalls < 0) ? int'($urandom_range(0, 2)) : stalls;
        for (int s = 0; s < ns; s++) step(path[i], op, fn, 1'b0, 1'b0, zf);
        step(path[i], op, fn, 1'b1, 1'b0, zf);
      end else begin
        step(path[i], op, fn, 1'($urandom_range(0, 1)), 1'b0, zf);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    ctrl_t act;
    ctrl_t exp;
    string tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = '{state, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, pc_en, illegal_op, alu_src_b, pc_src,
                alu_ctrl};
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    step(PH_FETCH, 6'd0, 6'd0, 1'b1, 1'b1, -1);   // reset: outputs all 0
    step(PH_FETCH, 6'd0, 6'd0, 1'b1, 1'b1, -1);

    run_instr(K_LW,   0, -1, -1, -1);             // 0,1,2,3,4
    run_instr(K_SW,   3, -1, -1, -1);             // mem_write 4 cycles
    run_instr(K_R,    0, -1, 42, -1);             // slt -> 111
    run_instr(K_RBAD, 0, -1,  7, -1);             // funct 000111 illegal
    run_instr(K_BEQ,  0,  1, -1, -1);             // taken
    run_instr(K_BEQ,  0,  0, -1, -1);             // not taken
    run_instr(K_ADDI, 0, -1, -1, -1);
    run_instr(K_J,    0, -1, -1, -1);
    run_instr(K_BADOP, 0, -1, -1, -1);
    run_instr(K_LW,   2, -1, -1, 3);              // reset while stalled in MEMRD
    run_instr(K_LW,   1, -1, -1, -1);             // resumes from FETCH

    for (int n = 0; n < 400; n++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 7));
      run_instr(k, -1, -1, -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
